divider_top: RTL and testbench

// - Iterative RV32M divide unit (DIV, DIVU, REM, REMU). Counterpart of the multiplier in the M-extension accelerator.
// - Uses the same start/done handshake as the multiplier so the core drives both units identically.
// - Radix-2 restoring division on operand magnitudes, then sign fix-up and RISC-V special-case override.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_if.sv | 29 ++
 rtl/divider_dp.sv | 96 +++++++++
 rtl/divider_top.sv | 75 +++++++
 tb/tb_divider_top.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide unit.
//   div_state_e : control FSM states
//   XLEN_DEF    : default operand/result width
//   DIV_LAT     : rising edges from the start edge (counted as the first) to the done pulse
package div_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned DIV_LAT  = XLEN_DEF + 3;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Start/done request interface of the divide unit (same shape as the multiplier's).
//   div_en_i        : start request
//   op_A_i, op_B_i  : dividend, divisor
//   signed_i        : 1 = DIV/REM, 0 = DIVU/REMU
//   rem_i           : 1 = remainder, 0 = quotient
//   result_o        : registered result
//   done_o          : one-cycle completion pulse
// master modport is the requester (core or bench), slave modport is the divider.
interface div_if #(
  parameter int unsigned XLEN = div_pkg::XLEN_DEF
);
  logic            div_en_i;
  logic [XLEN-1:0] op_A_i;
  logic [XLEN-1:0] op_B_i;
  logic            signed_i;
  logic            rem_i;
  logic [XLEN-1:0] result_o;
  logic            done_o;

  modport master (
    output div_en_i, op_A_i, op_B_i, signed_i, rem_i,
    input  result_o, done_o
  );

  modport slave (
    input  div_en_i, op_A_i, op_B_i, signed_i, rem_i,
    output result_o, done_o
  );
endinterface

// File: rtl/divider_dp.sv
// Datapath of the divide unit: operand latches, magnitude/sign preparation, one restoring
// division step per cycle, and the sign / divide-by-zero fix-up into the result register.
//   clk_i, rst_i            : clock, async active-low reset
//   load_i                  : latch operands and op type
//   prep_i                  : form magnitudes, signs and div0 flag
//   step_i                  : one radix-2 restoring step
//   fix_i                   : apply fix-up and register the result
//   op_a_i, op_b_i          : dividend, divisor
//   signed_i, rem_i         : op type
//   result_o                : registered result
module divider_dp
  import div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            prep_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            signed_i,
  input  logic            rem_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] a_q, b_q, b_abs_q, q_q, r_q, result_q;
  logic            signed_q, rem_q, neg_q_q, neg_r_q, div0_q;

  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [XLEN:0]   r_shift, r_sub;

  always_comb begin
    a_abs   = (signed_q && a_q[XLEN-1]) ? (~a_q + XLEN'(1)) : a_q;
    b_abs   = (signed_q && b_q[XLEN-1]) ? (~b_q + XLEN'(1)) : b_q;
    // Partial remainder is XLEN+1 bits so the compare/subtract cannot overflow.
    r_shift = {r_q, q_q[XLEN-1]};
    r_sub   = r_shift - {1'b0, b_abs_q};
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else begin
      q_fix = neg_q_q ? (~q_q + XLEN'(1)) : q_q;
      r_fix = neg_r_q ? (~r_q + XLEN'(1)) : r_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      b_abs_q  <= '0;
      q_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      if (load_i) begin
        a_q      <= op_a_i;
        b_q      <= op_b_i;
        signed_q <= signed_i;
        rem_q    <= rem_i;
      end
      if (prep_i) begin
        q_q     <= a_abs;
        b_abs_q <= b_abs;
        r_q     <= '0;
        neg_q_q <= signed_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_r_q <= signed_q & a_q[XLEN-1];
        div0_q  <= (b_q == '0);
      end
      if (step_i) begin
        // No borrow out of the subtract means shifted R >= |B|.
        if (!r_sub[XLEN]) begin
          r_q <= r_sub[XLEN-1:0];
          q_q <= {q_q[XLEN-2:0], 1'b1};
        end else begin
          r_q <= r_shift[XLEN-1:0];
          q_q <= {q_q[XLEN-2:0], 1'b0};
        end
      end
      if (fix_i) begin
        result_q <= rem_q ? r_fix : q_fix;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/divider_top.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with a start/done handshake.
// Sequence: IDLE -> PREP -> ITER (XLEN steps) -> FIX -> DONE; a request seen in DONE
// restarts directly into PREP, so held requests complete every XLEN+3 cycles.
//   clk_i : clock, rising edge
//   rst_i : async active-low reset
//   bus   : div_if slave (request, operands, op type, result, done pulse)
module divider_top
  import div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input logic clk_i,
  input logic rst_i,
  div_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            start, prep, step, fix;

  // Requests are only honoured when idle or finishing; busy-time requests are dropped.
  assign start = bus.div_en_i && ((state_q == StIdle) || (state_q == StDone));
  assign prep  = (state_q == StPrep);
  assign step  = (state_q == StIter);
  assign fix   = (state_q == StFix);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: if (start) state_q <= StPrep;
        StPrep: begin
          state_q <= StIter;
          cnt_q   <= '0;
        end
        StIter: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(XLEN - 1)) state_q <= StFix;
        end
        StFix: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone:  state_q <= start ? StPrep : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.done_o = done_q;

  divider_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (start),
    .prep_i   (prep),
    .step_i   (step),
    .fix_i    (fix),
    .op_a_i   (bus.op_A_i),
    .op_b_i   (bus.op_B_i),
    .signed_i (bus.signed_i),
    .rem_i    (bus.rem_i),
    .result_o (bus.result_o)
  );

endmodule

// File: tb/tb_divider_top.sv
// Directed bench for divider_top: hand-computed quotients/remainders, latency,
// busy-time request rejection, back-to-back throughput and asynchronous reset abort.
module tb_divider_top;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   cnt;

  div_if #(.XLEN(32)) bus ();

  divider_top #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; returns 1 microsecond-free just after the start edge,
  // with the start edge counted as edge 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic r);
    @(negedge clk);
    bus.op_A_i   = a;
    bus.op_B_i   = b;
    bus.signed_i = s;
    bus.rem_i    = r;
    bus.div_en_i = 1'b1;
    @(posedge clk);
    #1;
    bus.div_en_i = 1'b0;
  endtask

  // Count edges until done_o is seen high, continuing from n0; bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic r, input logic [31:0] exp);
    int n;
    start_op(a, b, s, r);
    wait_done(1, n);
    check({tag, "_lat"}, 32'(n), 32'(div_pkg::DIV_LAT));
    check(tag, bus.result_o, exp);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    bus.div_en_i = 1'b0;
    bus.op_A_i   = '0;
    bus.op_B_i   = '0;
    bus.signed_i = 1'b0;
    bus.rem_i    = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result_o, 32'h0);
    check("reset_done", 32'(bus.done_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000000E);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done_o), 32'h0);
    run_op("u100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'h00000002);
    run_op("s_m7_2_q", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD);
    run_op("s_m7_2_r", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF);
    run_op("u_max_1_q", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF);
    run_op("u_max_1_r", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'h00000000);
    run_op("s_m5_0_q", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF);
    run_op("s_m5_0_r", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFB);
    run_op("u_5_0_q", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
    run_op("u_5_0_r", 32'd5, 32'd0, 1'b0, 1'b1, 32'h00000005);
    run_op("s_ovf_q", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000);
    run_op("s_ovf_r", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000);
    run_op("u_ovf_q", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000);
    run_op("u_ovf_r", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000);

    // Busy: operands change and a request pulses mid-operation.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.op_A_i   = 32'd1;
    bus.op_B_i   = 32'd1;
    bus.signed_i = 1'b1;
    bus.rem_i    = 1'b1;
    bus.div_en_i = 1'b1;
    @(negedge clk);
    bus.div_en_i = 1'b0;
    wait_done(11, lat);
    check("busy_lat", 32'(lat), 32'd35);
    check("busy_result", bus.result_o, 32'h0000000E);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1) cnt++;
    end
    check("busy_no_extra_done", 32'(cnt), 32'd0);

    // Back-to-back with the request held high.
    @(negedge clk);
    bus.op_A_i   = 32'd100;
    bus.op_B_i   = 32'd7;
    bus.signed_i = 1'b0;
    bus.rem_i    = 1'b1;
    bus.div_en_i = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1, lat);
    check("b2b_first_lat", 32'(lat), 32'd35);
    check("b2b_first_res", bus.result_o, 32'h00000002);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      wait_done(1, lat);
      check("b2b_period", 32'(lat), 32'd35);
      check("b2b_res", bus.result_o, 32'h00000002);
    end
    @(negedge clk);
    bus.div_en_i = 1'b0;
    repeat (3) @(posedge clk);

    // Asynchronous reset part-way through an operation.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", bus.result_o, 32'h0);
    check("rst_mid_done", 32'(bus.done_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1) cnt++;
    end
    check("rst_no_done", 32'(cnt), 32'd0);
    run_op("post_rst_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 32'h00000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
